atm_account_responder: RTL and testbench

//   Bank-side responder for the ATM session controller. Accepts one request at a time over a

---
 rtl/atm_account_responder.sv | 183 ++++++++++++++++++
 tb/tb_atm_account_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_responder.sv
// Bank-side account responder: one request at a time over valid/ready, evaluated in a
// single EXEC cycle, answered with status and the stored balance over valid/ready.
module atm_account_responder #(
  parameter int unsigned BAL_W     = 5,
  parameter int unsigned INIT_BAL  = 16,
  parameter logic [3:0]  PIN_CODE  = 4'b1111,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [3:0]       req_pin,
  input  logic [BAL_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance,
  output logic             o_session,
  output logic             o_locked
);

  localparam logic [2:0] OP_PIN    = 3'b000;
  localparam logic [2:0] OP_DEP    = 3'b001;
  localparam logic [2:0] OP_WITH   = 3'b010;
  localparam logic [2:0] OP_BAL    = 3'b011;
  localparam logic [2:0] OP_XFER   = 3'b100;
  localparam logic [2:0] OP_LOGOUT = 3'b101;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_AUTH = 2'b01;
  localparam logic [1:0] ST_INSF = 2'b10;
  localparam logic [1:0] ST_OVF  = 2'b11;

  localparam logic [BAL_W-1:0] INIT_BAL_V = BAL_W'(INIT_BAL);
  localparam logic [2:0]       MAX_T      = 3'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [3:0]       r_pin;
  logic [BAL_W-1:0] r_amt;
  logic [BAL_W-1:0] r_balance;
  logic             r_session;
  logic [2:0]       r_tries;
  logic             r_locked;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_status;

  logic [BAL_W:0]   w_sum;
  logic             w_short;
  logic [2:0]       w_tries_inc;
  logic [1:0]       w_status;
  logic [BAL_W-1:0] w_balance;
  logic             w_session;
  logic [2:0]       w_tries;
  logic             w_locked;

  assign w_sum       = {1'b0, r_balance} + {1'b0, r_amt};
  assign w_short     = (r_amt > r_balance);
  assign w_tries_inc = (r_tries < MAX_T) ? (r_tries + 3'd1) : r_tries;

  // Outcome of the latched request, applied to the account state in EXEC.
  always_comb begin
    w_status  = ST_OK;
    w_balance = r_balance;
    w_session = r_session;
    w_tries   = r_tries;
    w_locked  = r_locked;
    if (r_op[2:1] == 2'b11) begin
      w_status = ST_OVF;
    end else if (r_locked && (r_op != OP_LOGOUT)) begin
      w_status = ST_AUTH;
    end else begin
      case (r_op)
        OP_PIN: begin
          if (r_pin == PIN_CODE) begin
            w_session = 1'b1;
            w_tries   = 3'd0;
          end else begin
            w_status  = ST_AUTH;
            w_session = 1'b0;
            w_tries   = w_tries_inc;
            w_locked  = r_locked | (w_tries_inc >= MAX_T);
          end
        end
        OP_LOGOUT: w_session = 1'b0;
        default: begin
          if (!r_session) begin
            w_status = ST_AUTH;
          end else begin
            case (r_op)
              OP_DEP: begin
                if (w_sum[BAL_W]) begin
                  w_status = ST_OVF;
                end else begin
                  w_balance = w_sum[BAL_W-1:0];
                end
              end
              OP_WITH, OP_XFER: begin
                // A failed debit also ends the session.
                if (w_short) begin
                  w_status  = ST_INSF;
                  w_session = 1'b0;
                end else begin
                  w_balance = r_balance - r_amt;
                end
              end
              OP_BAL:  w_status = ST_OK;
              default: w_status = ST_OK;
            endcase
          end
        end
      endcase
    end
  end

  // Request/execute/respond sequencer owning all account state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_pin        <= 4'd0;
      r_amt        <= '0;
      r_balance    <= INIT_BAL_V;
      r_session    <= 1'b0;
      r_tries      <= 3'd0;
      r_locked     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_pin   <= req_pin;
            r_amt   <= req_amount;
            r_state <= S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_rsp_status <= w_status;
          r_balance    <= w_balance;
          r_session    <= w_session;
          r_tries      <= w_tries;
          r_locked     <= w_locked;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          // First RESP cycle raises valid; rsp_ready only counts once valid is up.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE) && !rst;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_status  = r_rsp_status;
  assign rsp_balance = r_balance;
  assign o_session   = r_session;
  assign o_locked    = r_locked;

endmodule

// File: tb/tb_atm_account_responder.sv
// Randomized and directed bench for atm_account_responder, scored against a
// behavioural account model.
module tb_atm_account_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [3:0] req_pin = 4'd0;
  logic [4:0] req_amount = 5'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_status;
  logic [4:0] rsp_balance;
  logic       o_session;
  logic       o_locked;

  int n_tests = 0;
  int n_fail  = 0;

  int m_bal   = 16;
  int m_tries = 0;
  bit m_sess  = 1'b0;
  bit m_lock  = 1'b0;

  atm_account_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_pin(req_pin), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .o_session(o_session), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Account rules as plain arithmetic on integers.
  task automatic model_exec(input int op, input int pin, input int amt, output int st);
    st = 0;
    if (op >= 6) st = 3;
    else if (m_lock && op != 5) st = 1;
    else if (op == 0) begin
      if (pin == 15) begin m_sess = 1'b1; m_tries = 0; end
      else begin
        st = 1; m_sess = 1'b0;
        if (m_tries < 3) m_tries = m_tries + 1;
        if (m_tries >= 3) m_lock = 1'b1;
      end
    end
    else if (op == 5) m_sess = 1'b0;
    else if (!m_sess) st = 1;
    else if (op == 1) begin
      if (m_bal + amt > 31) st = 3; else m_bal = m_bal + amt;
    end
    else if (op == 2 || op == 4) begin
      if (amt > m_bal) begin st = 2; m_sess = 1'b0; end
      else m_bal = m_bal - amt;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_balance", {27'd0, rsp_balance}, 32'd16);
    chk("rst_session", {31'd0, o_session}, 32'd0);
    chk("rst_locked", {31'd0, o_locked}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_bal = 16; m_tries = 0; m_sess = 1'b0; m_lock = 1'b0;
    #1;
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_txn(input logic [2:0] op, input logic [3:0] pin, input logic [4:0] amt,
                        input int hold, input bit intrude);
    int st;
    int waitc;
    logic [1:0] h_st;
    logic [4:0] h_bal;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_pin = pin; req_amount = amt;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(waitc), 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_exec(int'(op), int'(pin), int'(amt), st);
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom_range(0, 7)); rsp_ready = 1'($urandom_range(0, 1));
    chk("lat1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'($urandom_range(0, 1));
    chk("lat2_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_status", {30'd0, rsp_status}, 32'(st));
    chk("rsp_balance", {27'd0, rsp_balance}, 32'(m_bal));
    chk("session", {31'd0, o_session}, {31'd0, m_sess});
    chk("locked", {31'd0, o_locked}, {31'd0, m_lock});
    h_st = rsp_status; h_bal = rsp_balance;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      if (intrude) begin
        req_valid = 1'b1; req_op = 3'($urandom_range(0, 7)); req_amount = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_status", {30'd0, rsp_status}, {30'd0, h_st});
      chk("hold_balance", {27'd0, rsp_balance}, {27'd0, h_bal});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    do_reset();

    // Login, deposit, withdraw.
    do_txn(3'b000, 4'hF, 5'd0, 0, 1'b0);
    do_txn(3'b001, 4'h0, 5'd2, 0, 1'b0);
    chk("t1_dep_bal", {27'd0, rsp_balance}, 32'd18);
    do_txn(3'b010, 4'h0, 5'd15, 1, 1'b0);
    chk("t1_bal", {27'd0, rsp_balance}, 32'd3);
    chk("t1_st", {30'd0, rsp_status}, 32'd0);

    // Insufficient funds drops the session.
    do_reset();
    do_txn(3'b000, 4'hF, 5'd0, 0, 1'b0);
    do_txn(3'b010, 4'h0, 5'd17, 0, 1'b0);
    chk("t2_st", {30'd0, rsp_status}, 32'd2);
    chk("t2_sess", {31'd0, o_session}, 32'd0);
    do_txn(3'b011, 4'h0, 5'd0, 0, 1'b0);
    chk("t2_bal_st", {30'd0, rsp_status}, 32'd1);

    // Lockout after three wrong PINs.
    do_reset();
    for (int i = 0; i < 3; i++) do_txn(3'b000, 4'h0, 5'd0, 0, 1'b0);
    chk("t3_locked", {31'd0, o_locked}, 32'd1);
    do_txn(3'b000, 4'hF, 5'd0, 0, 1'b0);
    chk("t3_pin_st", {30'd0, rsp_status}, 32'd1);
    do_txn(3'b101, 4'h0, 5'd0, 0, 1'b0);
    chk("t3_still_locked", {31'd0, o_locked}, 32'd1);
    do_reset();

    // Overflow, full transfer, illegal op.
    do_txn(3'b000, 4'hF, 5'd0, 0, 1'b0);
    do_txn(3'b001, 4'h0, 5'd20, 0, 1'b0);
    chk("t4_ovf", {30'd0, rsp_status}, 32'd3);
    do_txn(3'b100, 4'h0, 5'd16, 0, 1'b0);
    chk("t4_zero", {27'd0, rsp_balance}, 32'd0);
    do_txn(3'b110, 4'h0, 5'd0, 0, 1'b0);
    chk("t4_ill", {30'd0, rsp_status}, 32'd3);

    // Back-pressure with an intruding request.
    do_txn(3'b011, 4'h0, 5'd0, 5, 1'b1);

    // Reset during EXEC of a deposit.
    do_reset();
    do_txn(3'b000, 4'hF, 5'd0, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b001; req_amount = 5'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_bal", {27'd0, rsp_balance}, 32'd16);
    chk("t6_sess", {31'd0, o_session}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_bal = 16; m_tries = 0; m_sess = 1'b0; m_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Random traffic.
    for (int n = 0; n < 1200; n++) begin
      logic [3:0] pin;
      if ($urandom_range(0, 24) == 0) do_reset();
      pin = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      do_txn(3'($urandom_range(0, 7)), pin, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
